ws2812_scheduler: RTL and testbench
===================================

WS2812_SCHEDULER -- requirements
Module: ws2812_scheduler

Interface
REQ-001 The block SHALL take parameter NUM_LEDS, default 8, meaning the LED count on the strip; valid range is 1..255.
REQ-002 The block SHALL take parameter WRITE_GAP, default 4, meaning the minimum idle cycles between successive ws_write pulses; valid range is 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports a_valid (in, 1), a_ready (out, 1), a_led_num (in, 8) and a_rgb (in, 24): requester A pixel write.
REQ-006 The block SHALL have ports b_valid (in, 1), b_ready (out, 1), b_led_num (in, 8) and b_rgb (in, 24): requester B pixel write.
REQ-007 The block SHALL have ports fill_start (in, 1) and fill_rgb (in, 24): a request to paint every LED with one colour.
REQ-008 The block SHALL have ports ws_write (out, 1), ws_led_num (out, 8) and ws_rgb (out, 24): the command interface to the ws2812 core.
REQ-009 The block SHALL have output busy (1 bit), high whenever the state is not IDLE or a fill is pending.
REQ-010 The block SHALL have output drop_err (1 bit): a one-cycle pulse when an accepted write is discarded.

Function
REQ-011 The FSM SHALL have states IDLE, ISSUE, GAP and FILL.
REQ-012 A transfer SHALL occur on any cycle where valid and ready are both high; ready SHALL be asserted only in IDLE with no fill pending.
REQ-013 In IDLE, ready SHALL be a combinational function of the state, the valid inputs and last_grant; no ready SHALL ever depend on the requester's own ready.
REQ-014 Arbitration SHALL be round-robin: if only one requester is valid it is readied; if both are valid, the one not in last_grant is readied; last_grant updates on each transfer.
REQ-015 On a transfer with led_num < NUM_LEDS, the block SHALL latch led_num and rgb into ws_led_num/ws_rgb and enter ISSUE.
REQ-016 In ISSUE, ws_write SHALL pulse high for exactly one cycle (the cycle after the transfer); the block then enters GAP.
REQ-017 ws_led_num and ws_rgb SHALL hold stable from the ws_write cycle until the next load.
REQ-018 GAP SHALL last exactly WRITE_GAP cycles, then return to IDLE, or to FILL if a fill is pending.
REQ-019 On a transfer with led_num >= NUM_LEDS, the block SHALL pulse drop_err the next cycle, emit no ws_write, skip GAP and stay in IDLE, with last_grant still updated.
REQ-020 A fill_start pulse SHALL latch fill_rgb and set fill_pending; fill_start while fill_pending or in FILL SHALL be ignored.
REQ-021 From IDLE with fill_pending, the block SHALL enter FILL; fill takes priority over simultaneous a_valid/b_valid, and fill_start in the same cycle as a valid drops ready.
REQ-022 FILL SHALL issue NUM_LEDS writes to led 0..NUM_LEDS-1 in ascending order, each followed by WRITE_GAP idle cycles.
REQ-023 After the final fill write and its gap, fill_pending SHALL clear and the block SHALL return to IDLE.
REQ-024 The led index counter SHALL be 8 bits wide and SHALL never wrap past NUM_LEDS-1.

Reset
REQ-025 Assertion of reset_n low SHALL asynchronously force state to IDLE, with ws_write, a_ready, b_ready, drop_err and busy at 0.
REQ-026 Reset SHALL force ws_led_num, ws_rgb and the fill colour to 0, fill_pending to 0, and last_grant to B so that A wins first.
REQ-027 Reset asserted mid-fill or mid-gap SHALL abandon the operation with no further ws_write after deassertion.
REQ-028 Reset deassertion SHALL be synchronised in the parent; the block assumes a clean release.

Structure
REQ-029 The state encoding, the 24-bit RGB width and the 8-bit LED index width SHALL reside in the shared package ws2812_pkg.
REQ-030 The block SHALL contain one sub-module, ws2812_rr_arb: a 2-way round-robin arbiter with a last_grant register.

Verification
REQ-031 After reset, A and B both valid every cycle SHALL produce grants alternating A,B,A,B, with successive ws_write pulses spaced exactly WRITE_GAP+2 cycles apart.
REQ-032 A single A write of led 3, rgb 0x100000, SHALL produce ws_write one cycle after the transfer with ws_led_num=3 and ws_rgb=0x100000.
REQ-033 A write to led_num 8 with NUM_LEDS=8 SHALL produce a drop_err pulse, no ws_write, and a_ready high again the next cycle.
REQ-034 fill_start with rgb 0x001000 SHALL produce 8 writes to leds 0..7, all 0x001000; B valid throughout SHALL see b_ready low until fill completes.
REQ-035 Taking reset_n low during the 4th fill write's gap SHALL force all outputs to 0 immediately, with no ws_write after release and busy at 0.
REQ-036 fill_start and a_valid in the same IDLE cycle SHALL serve the fill first, with the A write issued afterwards.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared types and widths for the ws2812 command scheduler and its arbiter.
package ws2812_pkg;

  localparam int RGB_W = 24;
  localparam int LED_W = 8;

  typedef logic [RGB_W-1:0] rgb_t;
  typedef logic [LED_W-1:0] led_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2,
    ST_FILL  = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  function automatic logic led_in_range(input led_t led, input led_t last_led);
    return (led <= last_led);
  endfunction

endpackage

// File: rtl/ws2812_rr_arb.sv
// Two-way round-robin arbiter; ready is combinational, last_grant is registered.
module ws2812_rr_arb
  import ws2812_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_ready,
  output logic b_ready
);

  grant_e last_grant_r;

  assign a_ready = en & a_valid & (~b_valid | (last_grant_r == GRANT_B));
  assign b_ready = en & b_valid & (~a_valid | (last_grant_r == GRANT_A));

  // Remember the most recent winner so the other side wins a tie next time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_r <= GRANT_B;
    end else if (a_ready) begin
      last_grant_r <= GRANT_A;
    end else if (b_ready) begin
      last_grant_r <= GRANT_B;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/ws2812_scheduler.sv
// Schedules pixel writes from two requesters and whole-strip fills onto a ws2812 core,
// enforcing a minimum gap between successive ws_write pulses.
module ws2812_scheduler
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS  = 8,
  parameter int WRITE_GAP = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [LED_W-1:0] a_led_num,
  input  logic [RGB_W-1:0] a_rgb,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [LED_W-1:0] b_led_num,
  input  logic [RGB_W-1:0] b_rgb,
  input  logic             fill_start,
  input  logic [RGB_W-1:0] fill_rgb,
  output logic             ws_write,
  output logic [LED_W-1:0] ws_led_num,
  output logic [RGB_W-1:0] ws_rgb,
  output logic             busy,
  output logic             drop_err
);

  localparam led_t LAST_LED = led_t'(NUM_LEDS - 1);
  localparam led_t GAP_LAST = led_t'(WRITE_GAP - 1);

  state_e state_r, state_next_s;
  led_t   gap_cnt_r, gap_cnt_next_s;
  led_t   fill_idx_r, fill_idx_next_s;
  logic   fill_pending_r, fill_pending_next_s;
  logic   fill_active_r, fill_active_next_s;
  rgb_t   fill_rgb_r, fill_rgb_next_s;
  logic   load_s, drop_s;
  led_t   load_led_s;
  rgb_t   load_rgb_s;
  logic   arb_en_s, xfer_a_s, xfer_b_s, fill_take_s;

  logic   ws_write_r, busy_r, drop_err_r;
  led_t   ws_led_num_r;
  rgb_t   ws_rgb_r;

  // A fill request, even one arriving this cycle, blocks new pixel transfers.
  assign arb_en_s    = reset_n & (state_r == ST_IDLE) & ~fill_pending_r & ~fill_start;
  assign xfer_a_s    = a_valid & a_ready;
  assign xfer_b_s    = b_valid & b_ready;
  assign fill_take_s = fill_start & ~fill_pending_r & (state_r != ST_FILL);

  ws2812_rr_arb u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (arb_en_s),
    .a_valid (a_valid),
    .b_valid (b_valid),
    .a_ready (a_ready),
    .b_ready (b_ready)
  );

  // Next-state, fill bookkeeping and output-load decisions.
  always_comb begin
    state_next_s        = state_r;
    gap_cnt_next_s      = gap_cnt_r;
    fill_idx_next_s     = fill_idx_r;
    fill_active_next_s  = fill_active_r;
    fill_pending_next_s = fill_pending_r;
    fill_rgb_next_s     = fill_rgb_r;
    load_s              = 1'b0;
    drop_s              = 1'b0;
    load_led_s          = 8'd0;
    load_rgb_s          = 24'd0;

    if (fill_take_s) begin
      fill_pending_next_s = 1'b1;
      fill_rgb_next_s     = fill_rgb;
    end else begin
      fill_pending_next_s = fill_pending_r;
      fill_rgb_next_s     = fill_rgb_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (fill_pending_r) begin
          state_next_s       = ST_FILL;
          fill_active_next_s = 1'b1;
          load_s             = 1'b1;
          load_led_s         = fill_idx_r;
          load_rgb_s         = fill_rgb_r;
        end else if (xfer_a_s | xfer_b_s) begin
          load_led_s = xfer_b_s ? b_led_num : a_led_num;
          load_rgb_s = xfer_b_s ? b_rgb : a_rgb;
          if (led_in_range(load_led_s, LAST_LED)) begin
            state_next_s = ST_ISSUE;
            load_s       = 1'b1;
          end else begin
            drop_s = 1'b1;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE, ST_FILL: begin
        state_next_s   = ST_GAP;
        gap_cnt_next_s = 8'd0;
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          gap_cnt_next_s = 8'd0;
          if (fill_active_r) begin
            if (fill_idx_r == LAST_LED) begin
              state_next_s        = ST_IDLE;
              fill_pending_next_s = 1'b0;
              fill_active_next_s  = 1'b0;
              fill_idx_next_s     = 8'd0;
            end else begin
              state_next_s    = ST_FILL;
              fill_idx_next_s = fill_idx_r + 8'd1;
              load_s          = 1'b1;
              load_led_s      = fill_idx_r + 8'd1;
              load_rgb_s      = fill_rgb_r;
            end
          end else if (fill_pending_r) begin
            state_next_s       = ST_FILL;
            fill_active_next_s = 1'b1;
            load_s             = 1'b1;
            load_led_s         = fill_idx_r;
            load_rgb_s         = fill_rgb_r;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          gap_cnt_next_s = gap_cnt_r + 8'd1;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and fill bookkeeping registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= ST_IDLE;
      gap_cnt_r      <= 8'd0;
      fill_idx_r     <= 8'd0;
      fill_active_r  <= 1'b0;
      fill_pending_r <= 1'b0;
      fill_rgb_r     <= 24'd0;
    end else begin
      state_r        <= state_next_s;
      gap_cnt_r      <= gap_cnt_next_s;
      fill_idx_r     <= fill_idx_next_s;
      fill_active_r  <= fill_active_next_s;
      fill_pending_r <= fill_pending_next_s;
      fill_rgb_r     <= fill_rgb_next_s;
    end
  end

  // Registered command and status outputs, derived from the upcoming state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ws_write_r   <= 1'b0;
      ws_led_num_r <= 8'd0;
      ws_rgb_r     <= 24'd0;
      busy_r       <= 1'b0;
      drop_err_r   <= 1'b0;
    end else begin
      ws_write_r <= (state_next_s == ST_ISSUE) | (state_next_s == ST_FILL);
      busy_r     <= (state_next_s != ST_IDLE) | fill_pending_next_s;
      drop_err_r <= drop_s;
      if (load_s) begin
        ws_led_num_r <= load_led_s;
        ws_rgb_r     <= load_rgb_s;
      end else begin
        ws_led_num_r <= ws_led_num_r;
        ws_rgb_r     <= ws_rgb_r;
      end
    end
  end

  assign ws_write   = ws_write_r;
  assign ws_led_num = ws_led_num_r;
  assign ws_rgb     = ws_rgb_r;
  assign busy       = busy_r;
  assign drop_err   = drop_err_r;

endmodule

// File: tb/tb_ws2812_scheduler.sv
// Directed self-checking bench for ws2812_scheduler with NUM_LEDS=8, WRITE_GAP=4.
module tb_ws2812_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0, fill_start = 1'b0;
  logic [7:0]  a_led_num = 8'd0, b_led_num = 8'd0;
  logic [23:0] a_rgb = 24'd0, b_rgb = 24'd0, fill_rgb = 24'd0;
  logic        a_ready, b_ready, ws_write, busy, drop_err;
  logic [7:0]  ws_led_num;
  logic [23:0] ws_rgb;

  int n_checks = 0;
  int n_errors = 0;

  ws2812_scheduler #(.NUM_LEDS(8), .WRITE_GAP(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_led_num(a_led_num), .a_rgb(a_rgb),
    .b_valid(b_valid), .b_ready(b_ready), .b_led_num(b_led_num), .b_rgb(b_rgb),
    .fill_start(fill_start), .fill_rgb(fill_rgb),
    .ws_write(ws_write), .ws_led_num(ws_led_num), .ws_rgb(ws_rgb),
    .busy(busy), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    a_valid = 1'b0; b_valid = 1'b0; fill_start = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30 && busy; i++) @(negedge clk);
    check("wait_idle", busy, 1'b0);
  endtask

  // Fill of 8 LEDs colliding with a pixel request from A or B; the request is served last.
  task automatic run_fill(input logic use_b, input logic [23:0] frgb,
                          input logic [7:0] req_led, input logic [23:0] req_rgb);
    int nfill;
    int early;
    bit req_seen;
    @(negedge clk);
    fill_start = 1'b1; fill_rgb = frgb;
    if (use_b) begin b_valid = 1'b1; b_led_num = req_led; b_rgb = req_rgb; end
    else       begin a_valid = 1'b1; a_led_num = req_led; a_rgb = req_rgb; end
    #1;
    check("ready_drop_on_fill_start", use_b ? b_ready : a_ready, 1'b0);
    @(negedge clk);
    fill_start = 1'b0;
    nfill = 0; early = 0; req_seen = 1'b0;
    for (int i = 0; i < 120 && !req_seen; i++) begin
      fill_start = (i == 10);
      if (i == 10) fill_rgb = 24'hFFFFFF;
      if (nfill < 8 && (a_ready || b_ready)) early++;
      if (ws_write) begin
        if (nfill < 8) begin
          check("fill_led", ws_led_num, nfill[7:0]);
          check("fill_rgb", ws_rgb, frgb);
          nfill++;
        end else begin
          check("req_after_fill_led", ws_led_num, req_led);
          check("req_after_fill_rgb", ws_rgb, req_rgb);
          req_seen = 1'b1;
          a_valid = 1'b0; b_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    fill_start = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    check("fill_write_count", nfill, 8);
    check("req_served", req_seen, 1'b1);
    check("ready_during_fill", early, 0);
    wait_idle();
  endtask

  initial begin : main
    int wled[4];
    int wtime[4];
    logic [23:0] wrgb0;
    int nw;
    int cyc;
    int nfill;
    int nwrites;

    // Reset values with requests already waiting
    reset_n = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ws_write", ws_write, 1'b0);
    check("rst_led", ws_led_num, 8'd0);
    check("rst_rgb", ws_rgb, 24'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_drop", drop_err, 1'b0);
    check("rst_a_ready", a_ready, 1'b0);
    check("rst_b_ready", b_ready, 1'b0);
    a_valid = 1'b0; b_valid = 1'b0;
    reset_n = 1'b1;

    // Single A write: led 3, rgb 0x100000
    @(negedge clk);
    a_valid = 1'b1; a_led_num = 8'd3; a_rgb = 24'h100000;
    #1 check("single_a_ready", a_ready, 1'b1);
    @(negedge clk);
    a_valid = 1'b0;
    check("single_ws_write", ws_write, 1'b1);
    check("single_led", ws_led_num, 8'd3);
    check("single_rgb", ws_rgb, 24'h100000);
    check("single_busy", busy, 1'b1);
    @(negedge clk);
    check("single_write_one_cycle", ws_write, 1'b0);
    check("single_led_hold", ws_led_num, 8'd3);
    repeat (3) @(negedge clk);
    check("gap_still_busy", busy, 1'b1);
    @(negedge clk);
    check("gap_done_idle", busy, 1'b0);

    // Out-of-range LED 8 is dropped
    a_valid = 1'b1; a_led_num = 8'd8; a_rgb = 24'h0000AA;
    #1 check("drop_a_ready", a_ready, 1'b1);
    @(negedge clk);
    check("drop_err_pulse", drop_err, 1'b1);
    check("drop_no_write", ws_write, 1'b0);
    check("drop_a_ready_again", a_ready, 1'b1);
    check("drop_busy", busy, 1'b0);
    check("drop_led_unchanged", ws_led_num, 8'd3);
    a_valid = 1'b0;
    @(negedge clk);
    check("drop_err_one_cycle", drop_err, 1'b0);

    // Round-robin alternation from reset with both requesters always valid
    apply_reset();
    a_valid = 1'b1; a_led_num = 8'd1; a_rgb = 24'h00000A;
    b_valid = 1'b1; b_led_num = 8'd2; b_rgb = 24'h00000B;
    #1;
    check("rr_a_first", a_ready, 1'b1);
    check("rr_b_waits", b_ready, 1'b0);
    nw = 0; wrgb0 = 24'd0;
    for (cyc = 0; cyc < 80 && nw < 4; cyc++) begin
      @(negedge clk);
      if (ws_write) begin
        wled[nw] = int'(ws_led_num);
        wtime[nw] = cyc;
        if (nw == 0) wrgb0 = ws_rgb;
        nw++;
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    check("rr_write_count", nw, 4);
    if (nw == 4) begin
      check("rr_grant0", wled[0], 1);
      check("rr_grant1", wled[1], 2);
      check("rr_grant2", wled[2], 1);
      check("rr_grant3", wled[3], 2);
      check("rr_rgb0", wrgb0, 24'h00000A);
      for (int k = 1; k < 4; k++) check("rr_spacing", wtime[k] - wtime[k-1], 6);
    end
    wait_idle();

    // Fill with B waiting, then fill with A arriving in the same cycle
    run_fill(1'b1, 24'h001000, 8'd5, 24'h0000FF);
    run_fill(1'b0, 24'h000010, 8'd6, 24'h123456);

    // Reset during the gap after the 4th fill write
    @(negedge clk);
    fill_start = 1'b1; fill_rgb = 24'h0F0F0F;
    b_valid = 1'b1; b_led_num = 8'd2; b_rgb = 24'h000001;
    @(negedge clk);
    fill_start = 1'b0;
    nfill = 0;
    for (int i = 0; i < 60 && nfill < 4; i++) begin
      @(negedge clk);
      if (ws_write) nfill++;
    end
    check("mid_fill_reached_4", nfill, 4);
    @(negedge clk);
    check("mid_gap_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ws_write", ws_write, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_led", ws_led_num, 8'd0);
    check("mid_rst_rgb", ws_rgb, 24'd0);
    check("mid_rst_b_ready", b_ready, 1'b0);
    @(negedge clk);
    b_valid = 1'b0;
    reset_n = 1'b1;
    nwrites = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ws_write) nwrites++;
    end
    check("post_rst_no_write", nwrites, 0);
    check("post_rst_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
